bram_delay_ctrl: RTL and testbench

//  Streaming delay-line controller driving a single-port read-first BRAM (sp_bram) in the parent.

---
 rtl/bram_delay_ctrl_pkg.sv | 12 +
 rtl/bram_delay_ctrl_if.sv | 36 +++
 rtl/sp_bram.sv | 24 ++
 rtl/bram_delay_ctrl.sv | 81 ++++++++
 tb/tb_bram_delay_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/bram_delay_ctrl_pkg.sv
// Shared types for the BRAM delay-line controller.
package bram_delay_ctrl_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 2048;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/bram_delay_ctrl_if.sv
// Sample stream plus single-port BRAM bus around the delay controller.
interface bram_delay_ctrl_if
    import bram_delay_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      delay_len;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             busy;
    logic             bram_en;
    logic             bram_we;
    logic [AW-1:0]    bram_addr;
    logic [WIDTH-1:0] bram_din;
    logic [WIDTH-1:0] bram_dout;

    modport master (
        output delay_len, in_valid, in_data, out_ready, bram_dout,
        input  in_ready, out_valid, out_data, busy,
        input  bram_en, bram_we, bram_addr, bram_din
    );

    modport slave (
        input  delay_len, in_valid, in_data, out_ready, bram_dout,
        output in_ready, out_valid, out_data, busy,
        output bram_en, bram_we, bram_addr, bram_din
    );

endinterface

// File: rtl/sp_bram.sv
// Single-port read-first block RAM with registered output.
module sp_bram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2048,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (en_i) begin
            dout_o <= mem_q[addr_i];
            if (we_i) mem_q[addr_i] <= din_i;
        end
    end

endmodule

// File: rtl/bram_delay_ctrl.sv
// Ring-buffer delay line over a read-first BRAM; clears RAM after reset.
module bram_delay_ctrl
    import bram_delay_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst,
    bram_delay_ctrl_if.slave bus
);

    localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
    localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_END = AW'(DEPTH - 1);

    function automatic logic [AW:0] clamp_len(input logic [AW:0] d);
        if (d == '0) return LEN_ONE;
        if (d > LEN_MAX) return LEN_MAX;
        return d;
    endfunction

    state_e        state_q;
    logic [AW-1:0] clr_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   len_q;
    logic          out_valid_q;

    logic          in_ready;
    logic          accept;
    logic          wrap;
    logic          clearing;

    assign clearing = !rst && (state_q == ST_CLEAR);
    assign in_ready = !rst && (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
    assign accept   = in_ready && bus.in_valid;
    // Compare in AW+1 bits so len_q == DEPTH does not alias to zero.
    assign wrap     = ({1'b0, wr_ptr_q} == (len_q - LEN_ONE));

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = bus.bram_dout;
    assign bus.busy      = rst || (state_q == ST_CLEAR);
    assign bus.bram_en   = clearing || accept;
    assign bus.bram_we   = clearing || accept;
    assign bus.bram_addr = clearing ? clr_ptr_q : (accept ? wr_ptr_q : '0);
    assign bus.bram_din  = accept ? bus.in_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clr_ptr_q   <= '0;
            wr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            len_q       <= clamp_len(bus.delay_len);
        end else begin
            unique case (state_q)
                ST_CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + 1'b1;
                    if (clr_ptr_q == PTR_END) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (accept) begin
                        out_valid_q <= 1'b1;
                        if (wrap) begin
                            wr_ptr_q <= '0;
                            len_q    <= clamp_len(bus.delay_len);
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_delay_ctrl.sv
// Directed bench for bram_delay_ctrl with a 16-deep read-first BRAM.
module tb_bram_delay_ctrl;
    import bram_delay_ctrl_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bram_delay_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    bram_delay_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sp_bram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ram (
        .clk    (clk),
        .en_i   (bus.bram_en),
        .we_i   (bus.bram_we),
        .addr_i (bus.bram_addr),
        .din_i  (bus.bram_din),
        .dout_o (bus.bram_dout)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic [AW:0] len);
        @(negedge clk);
        rst           = 1'b1;
        bus.delay_len = len;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ov", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 1);
        chk("rst_en", 32'(bus.bram_en), 0);
        chk("rst_rdy", 32'(bus.in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("clr_busy", 32'(bus.busy), 1);
            chk("clr_we", 32'(bus.bram_we), 1);
            chk("clr_addr", 32'(bus.bram_addr), 32'(i));
            chk("clr_din", 32'(bus.bram_din), 0);
            chk("clr_rdy", 32'(bus.in_ready), 0);
            chk("clr_ov", 32'(bus.out_valid), 0);
            @(posedge clk);
            #1;
        end
        chk("run_busy", 32'(bus.busy), 0);
        chk("run_rdy", 32'(bus.in_ready), 1);
        chk("run_en", 32'(bus.bram_en), 0);
    endtask

    task automatic step(input logic iv, input logic [7:0] d,
                        input logic ordy, input logic exp_rdy,
                        input logic exp_ov, input logic [7:0] exp_od,
                        input logic chk_od);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("bram_en", 32'(bus.bram_en), 32'(iv && exp_rdy));
        @(posedge clk);
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        if (chk_od) chk("out_data", 32'(bus.out_data), 32'(exp_od));
    endtask

    task automatic push(input logic [7:0] d, input logic [7:0] exp,
                        input logic [AW-1:0] exp_addr);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.out_ready = 1'b1;
        #1;
        chk("push_rdy", 32'(bus.in_ready), 1);
        chk("push_addr", 32'(bus.bram_addr), 32'(exp_addr));
        chk("push_din", 32'(bus.bram_din), 32'(d));
        @(posedge clk);
        #1;
        chk("push_ov", 32'(bus.out_valid), 1);
        chk("push_od", 32'(bus.out_data), 32'(exp));
    endtask

    logic [7:0] exp4 [8] = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h1, 8'h2, 8'h3, 8'h4};

    initial begin
        bus.delay_len = 5'd4;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // delay 4: four zeros then the input stream
        do_reset(5'd4);
        for (int i = 0; i < 8; i++)
            push(8'(i + 1), exp4[i], 4'(i % 4));

        // delay 1: previous sample, pointer pinned at 0
        do_reset(5'd1);
        push(8'hA5, 8'h00, 4'd0);
        push(8'h5A, 8'hA5, 4'd0);

        // delay 0 clamps to 1
        do_reset(5'd0);
        push(8'h11, 8'h00, 4'd0);
        push(8'h22, 8'h11, 4'd0);

        // delay 31 clamps to 16
        do_reset(5'd31);
        for (int i = 0; i < 17; i++)
            push(8'(i + 1), (i == 16) ? 8'h01 : 8'h00, 4'(i % 16));

        // stall with out_ready low, then resume
        do_reset(5'd4);
        for (int i = 0; i < 5; i++)
            push(8'(i + 1), (i == 4) ? 8'h01 : 8'h00, 4'(i % 4));
        step(1'b1, 8'd6, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1);
        step(1'b1, 8'd6, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1);
        step(1'b1, 8'd6, 1'b1, 1'b1, 1'b1, 8'd2, 1'b1);
        step(1'b1, 8'd7, 1'b1, 1'b1, 1'b1, 8'd3, 1'b1);
        step(1'b1, 8'd8, 1'b1, 1'b1, 1'b1, 8'd4, 1'b1);
        step(1'b1, 8'd9, 1'b1, 1'b1, 1'b1, 8'd5, 1'b1);
        step(1'b1, 8'd10, 1'b1, 1'b1, 1'b1, 8'd6, 1'b1);
        step(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);

        // reset mid-stream: pending data dropped, RAM re-cleared
        push(8'd20, 8'd7, 4'd2);
        push(8'd21, 8'd8, 4'd3);
        do_reset(5'd4);
        for (int i = 0; i < 5; i++)
            push(8'(i + 7), (i == 4) ? 8'd7 : 8'd0, 4'(i % 4));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
